// File: rtl/rram_pkg.sv
// Shared types for the RRAM row controller: op / bias encodings, FSM states, request payload.
// WRITE_VERIFY_EN adds the VERIFY state used by the write-verify loop.
package rram_pkg;

    localparam int unsigned ROW_W     = 5;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_RETRY = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        WL_IDLE  = 2'b00,
        WL_READ  = 2'b01,
        WL_SET   = 2'b10,
        WL_RESET = 2'b11
    } wl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE
`ifdef WRITE_VERIFY_EN
        , ST_VERIFY
`endif
    } state_t;

    typedef struct packed {
        op_t              op;
        logic [ROW_W-1:0] row;
    } req_t;

    // Word-line bias that goes with an operation
    function automatic wl_t op_bias(op_t op);
        case (op)
            OP_READ:  return WL_READ;
            OP_SET:   return WL_SET;
            OP_RESET: return WL_RESET;
            default:  return WL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rram_row_ctrl_if.sv
// Request handshake between a requester (master) and the row controller (slave).
interface rram_row_ctrl_if;
    import rram_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [ROW_W-1:0] req_row;

    modport master (output req_valid, output req_op, output req_row, input req_ready);
    modport slave  (input req_valid, input req_op, input req_row, output req_ready);

endinterface

// File: rtl/rram_pulse_timer.sv
// Down-counter for PULSE / SETTLE phases: load takes width-1, stops at zero.
module rram_pulse_timer
    import rram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] width,
    output logic             done,
    output logic             near_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= width - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done   = (cnt_q == '0);
    // One cycle left before done: lets registered outputs anticipate the last cycle
    assign near_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rram_row_ctrl.sv
// RRAM row controller: sequences SETUP / PULSE / SETTLE on one word line per request.
// Define WRITE_VERIFY_EN to read back every SET/RESET and retry up to MAX_RETRY writes.
module rram_row_ctrl
    import rram_pkg::*;
#(
    parameter int unsigned PULSE_RD = 4,
    parameter int unsigned PULSE_WR = 8,
    parameter int unsigned SETTLE   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rram_row_ctrl_if.slave   req,
    output logic             dec_en,
    output logic [ROW_W-1:0] dec_din,
    output logic [1:0]       wl_mode,
    output logic             sa_strobe,
    input  logic             sa_bit,
    output logic             rd_valid,
    output logic             rd_data,
    output logic             err
);

    state_t           state_q, state_d;
    req_t             req_c;
    op_t              op_q, op_d;
    logic [ROW_W-1:0] row_d;
    logic             ready_q, ready_d, accept_c, rd_phase_d;
    logic             dec_en_d, sa_strobe_d, rd_valid_d, rd_data_d, err_d;
    wl_t              wl_mode_d;
    logic             tmr_load_c, tmr_done, tmr_near_c;
    logic [CNT_W-1:0] tmr_width_c;
`ifdef WRITE_VERIFY_EN
    logic             vfy_q, vfy_d;
    logic [1:0]       tries_q, tries_d;
    logic             last_try_c, pass_now_c, pass_q_c;

    assign last_try_c = (tries_q == 2'(MAX_RETRY));
    assign pass_now_c = (sa_bit  == (op_q == OP_SET));
    assign pass_q_c   = (rd_data == (op_q == OP_SET));
`endif

    assign req_c         = '{op: op_t'(req.req_op), row: req.req_row};
    assign accept_c      = req.req_valid && ready_q;
    assign req.req_ready = ready_q;

    rram_pulse_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load_c),
        .width  (tmr_width_c),
        .done   (tmr_done),
        .near_c (tmr_near_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            ready_q   <= 1'b0;
            dec_en    <= 1'b0;
            dec_din   <= '0;
            wl_mode   <= WL_IDLE;
            sa_strobe <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 1'b0;
            err       <= 1'b0;
`ifdef WRITE_VERIFY_EN
            vfy_q     <= 1'b0;
            tries_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ready_q   <= ready_d;
            dec_en    <= dec_en_d;
            dec_din   <= row_d;
            wl_mode   <= wl_mode_d;
            sa_strobe <= sa_strobe_d;
            rd_valid  <= rd_valid_d;
            rd_data   <= rd_data_d;
            err       <= err_d;
`ifdef WRITE_VERIFY_EN
            vfy_q     <= vfy_d;
            tries_q   <= tries_d;
`endif
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c && req_c.op != OP_RSVD) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_PULSE;
            ST_PULSE:  if (tmr_done) state_d = ST_SETTLE;
            ST_SETTLE: if (tmr_done) begin
                state_d = ST_IDLE;
`ifdef WRITE_VERIFY_EN
                if (!vfy_q && op_q != OP_READ)              state_d = ST_VERIFY;
                else if (vfy_q && !pass_q_c && !last_try_c) state_d = ST_SETUP;
`endif
            end
`ifdef WRITE_VERIFY_EN
            ST_VERIFY: state_d = ST_PULSE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values, registered above so every output is a flop
    always_comb begin
        op_d  = op_q;
        row_d = dec_din;
        if (accept_c && req_c.op != OP_RSVD) begin
            op_d  = req_c.op;
            row_d = req_c.row;
        end
`ifdef WRITE_VERIFY_EN
        vfy_d   = vfy_q;
        tries_d = tries_q;
        if (accept_c) begin
            vfy_d   = 1'b0;
            tries_d = 2'd1;
        end else if (state_d == ST_VERIFY) begin
            vfy_d = 1'b1;
        end else if (state_q == ST_SETTLE && state_d == ST_SETUP) begin
            vfy_d   = 1'b0;
            tries_d = tries_q + 2'd1;
        end
        rd_phase_d = (op_d == OP_READ) || vfy_d;
`else
        rd_phase_d = (op_d == OP_READ);
`endif
        ready_d   = (state_d == ST_IDLE);
        dec_en_d  = (state_d == ST_PULSE);
        wl_mode_d = WL_IDLE;
        if (state_d != ST_IDLE && state_d != ST_SETTLE) begin
            wl_mode_d = rd_phase_d ? WL_READ : op_bias(op_d);
        end

        tmr_load_c  = (state_d != state_q) && (state_d == ST_PULSE || state_d == ST_SETTLE);
        tmr_width_c = CNT_W'(SETTLE);
        if (state_d == ST_PULSE) begin
            tmr_width_c = rd_phase_d ? CNT_W'(PULSE_RD) : CNT_W'(PULSE_WR);
        end

        // Strobe lands on the last read-pulse cycle; sa_bit is captured at its closing edge
        sa_strobe_d = dec_en_d && rd_phase_d &&
                      ((state_q != ST_PULSE) ? (PULSE_RD == 1) : tmr_near_c);
        rd_data_d   = (state_q == ST_PULSE && sa_strobe) ? sa_bit : rd_data;

        rd_valid_d = 1'b0;
        err_d      = accept_c && (req_c.op == OP_RSVD);
        if (state_q == ST_PULSE && tmr_done) begin
            rd_valid_d = (op_q == OP_READ);
`ifdef WRITE_VERIFY_EN
            if (vfy_q && (pass_now_c || last_try_c)) begin
                rd_valid_d = 1'b1;
                err_d      = !pass_now_c;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rram_row_ctrl.sv
// Randomized bench for rram_row_ctrl: each request is traced cycle by cycle and compared
// against a transaction-level model of phase lengths, strobe timing and read-back results.
module tb_rram_row_ctrl;
    import rram_pkg::*;

    localparam int PR   = 4;
    localparam int PW   = 8;
    localparam int ST   = 2;
    localparam int T    = 2 + PW + PR + 2 * ST;
    localparam int KMAX = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_en, sa_strobe, sa_bit, rd_valid, rd_data, err;
    logic [4:0] dec_din;
    logic [1:0] wl_mode;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    sa_force = -1;
    int    last_row = 0;
    string cur = "reset";

    rram_row_ctrl_if bus ();

    rram_row_ctrl #(.PULSE_RD(PR), .PULSE_WR(PW), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .dec_en    (dec_en),
        .dec_din   (dec_din),
        .wl_mode   (wl_mode),
        .sa_strobe (sa_strobe),
        .sa_bit    (sa_bit),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got %0d, expected %0d", tag, cur, got, exp);
        end
    endtask

    function automatic logic next_bit();
        if (sa_force < 0) return 1'($urandom_range(0, 1));
        return 1'(sa_force);
    endfunction

    // Bias expected on the word line during dec_en segment seg (1-based)
    function automatic int exp_mode(int op, int seg);
        if (op == 0) return 1;
`ifdef WRITE_VERIFY_EN
        if (seg % 2 == 0) return 1;
`endif
        return op + 1;
    endfunction

    function automatic bit is_strb_pos(int op, int k);
        if (op == 0) return k == 1 + PR;
`ifdef WRITE_VERIFY_EN
        for (int i = 0; i < int'(MAX_RETRY); i++)
            if (op != 3 && k == i * T + 2 + PW + ST + PR) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Issue one request at a negedge with ready high, trace it until ready returns
    task automatic run_op(input int op, input int row, input bit hold);
        int bit_at[KMAX+1];
        int lat = -1, en_cyc = 0, seg = 0, din_bad = 0, mode_bad = 0;
        int strobes = 0, strb_bad = 0, rv_cnt = 0, rv_k = -1, rv_d = -1;
        int err_cnt = 0, err_k = -1, prev_en = 0;
        int e_lat, e_en, e_seg, e_strb, e_rv, e_rvk, e_rvd, e_err, e_errk;
        cur = $sformatf("op%0d row%0d", op, row);
        for (int i = 0; i <= KMAX; i++) bit_at[i] = 0;
        chk("ready_at_issue", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_row   = 5'(row);
        for (int k = 1; k <= KMAX && lat < 0; k++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            if (dec_en) begin
                en_cyc++;
                if (prev_en == 0) seg++;
                if (int'(dec_din) != row) din_bad++;
                if (int'(wl_mode) != exp_mode(op, seg)) mode_bad++;
            end
            if (sa_strobe) begin
                strobes++;
                if (!is_strb_pos(op, k)) strb_bad++;
            end
            if (rd_valid) begin rv_cnt++; rv_k = k; rv_d = int'(rd_data); end
            if (err) begin err_cnt++; err_k = k; end
            if (bus.req_ready) lat = k - 1;
            prev_en = int'(dec_en);
            sa_bit    = next_bit();
            bit_at[k] = int'(sa_bit);
        end
        if (lat < 0) chk("ready_timeout", 0, 1);

        // Reference: phase lengths and outcome from the request and the driven sense bits
        e_strb = 0; e_rv = 0; e_rvk = -1; e_rvd = -1; e_err = 0; e_errk = -1;
        if (op == 3) begin
            e_lat = 0; e_en = 0; e_seg = 0; e_err = 1; e_errk = 1;
        end else if (op == 0) begin
            e_lat = 1 + PR + ST; e_en = PR; e_seg = 1; e_strb = 1;
            e_rv = 1; e_rvk = e_lat - ST + 1; e_rvd = bit_at[1 + PR];
        end else begin
`ifdef WRITE_VERIFY_EN
            int n = 0;
            bit pass = 1'b0;
            int pos = 0;
            while (n < int'(MAX_RETRY) && !pass) begin
                pos  = n * T + 2 + PW + ST + PR;
                pass = (bit_at[pos] == ((op == 1) ? 1 : 0));
                n++;
            end
            e_lat = n * T; e_en = n * (PW + PR); e_seg = 2 * n; e_strb = n;
            e_rv = 1; e_rvk = e_lat - ST + 1; e_rvd = bit_at[pos];
            if (!pass) begin e_err = 1; e_errk = e_rvk; end
`else
            e_lat = 1 + PW + ST; e_en = PW; e_seg = 1;
`endif
        end

        chk("latency", lat, e_lat);
        chk("dec_en_cycles", en_cyc, e_en);
        chk("pulse_segments", seg, e_seg);
        chk("din_while_en_bad", din_bad, 0);
        chk("wl_mode_bad", mode_bad, 0);
        chk("strobes", strobes, e_strb);
        chk("strobe_pos_bad", strb_bad, 0);
        chk("rd_valid_cnt", rv_cnt, e_rv);
        chk("rd_valid_cycle", rv_k, e_rvk);
        chk("rd_data", rv_d, e_rvd);
        chk("err_cnt", err_cnt, e_err);
        chk("err_cycle", err_k, e_errk);
        if (op != 3) last_row = row;
        chk("idle_din", int'(dec_din), last_row);
    endtask

    // RESET row 0, pull rst_n low in the 3rd PULSE cycle
    task automatic reset_mid_pulse();
        cur = "reset mid-pulse";
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(OP_RESET);
        bus.req_row   = 5'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        chk("en_before_reset", int'(dec_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_dec_en", int'(dec_en), 0);
        chk("rst_dec_din", int'(dec_din), 0);
        chk("rst_wl_mode", int'(wl_mode), 0);
        chk("rst_sa_strobe", int'(sa_strobe), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        repeat (2) @(negedge clk);
        chk("ready_in_reset", int'(bus.req_ready), 0);
        chk("en_in_reset", int'(dec_en), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(bus.req_ready), 1);
        last_row = 0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_row   = 5'd0;
        sa_bit        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(bus.req_ready), 0);
        chk("reset_dec_en", int'(dec_en), 0);
        chk("reset_dec_din", int'(dec_din), 0);
        chk("reset_wl_mode", int'(wl_mode), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", int'(bus.req_ready), 1);

        sa_force = 1;
        run_op(0, 5, 1'b0);
        sa_force = -1;
        run_op(1, 31, 1'b0);
        run_op(3, 3, 1'b0);
        reset_mid_pulse();
        sa_force = 0;
        run_op(1, 7, 1'b0);
        sa_force = -1;
        run_op(0, 0, 1'b1);
        run_op(0, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
